operand_fetch: RTL and testbench
================================

# operand_fetch

Issue/operand-fetch pipeline stage placed between instruction decode and the ALU. It accepts decoded instructions, drives the register file's two read addresses, merges same-cycle writeback data through a bypass path, and tracks pending writes in a per-register scoreboard so that RAW/WAW hazards stall issue. Fetched operands leave through a one-entry valid/ready output register.

## Interface
- BUS_WIDTH, 8, data/operand width; matches the register file.
- DEPTH, 3, number of architectural registers; address width AW = $clog2(DEPTH).
- CTRL_WIDTH, 6, opaque decoded-control bundle passed through unchanged.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_ctrl  in  CTRL_WIDTH  control bundle.
- in_rs_a, in_rs_b  in  AW  source register addresses.
- in_rd  in  AW  destination register.
- in_rd_we  in  1  instruction writes in_rd.
- rf_rd_addr_a, rf_rd_addr_b  out  AW  register-file read addresses; combinational copy of in_rs_a/in_rs_b.
- rf_rd_data_a, rf_rd_data_b  in  BUS_WIDTH  register-file read data; asynchronous read, same cycle.
- wb_we, wb_addr (AW), wb_data (BUS_WIDTH)  in  writeback port; the same signals that drive the register-file write port.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  ALU consumes the bundle.
- out_ctrl  out  CTRL_WIDTH; out_op_a, out_op_b  out  BUS_WIDTH; out_rd  out  AW; out_rd_we  out  1.
- hazard_stall  out  1  in_valid high and issue blocked by the scoreboard.

## Operation
- Scoreboard: `pend[DEPTH-1:0]`, where one bit marks a register with an issued, not yet written-back write.
- Writeback clear: `clr(r) = wb_we && wb_addr==r && r<DEPTH`.
- Hazard term: `hz(r) = r<DEPTH && pend[r] && !clr(r)`.
- Hazard condition: `hazard = hz(in_rs_a) || hz(in_rs_b) || (in_rd_we && hz(in_rd))`.
- Ready: `in_ready = (!out_valid || out_ready) && !hazard`.
- Stall flag: `hazard_stall = in_valid && hazard`.
- Accept: `in_valid && in_ready`.
- On accept, the output register loads ctrl, rd and rd_we.
- On accept, operands are selected per source r:
  - 0 if r >= DEPTH.
  - Else wb_data if clr(r).
  - Else rf_rd_data.
- Scoreboard update, per edge:
  - `pend[r]` clears on clr(r).
  - `pend[r]` sets if accept && in_rd_we && in_rd==r && r<DEPTH.
  - If set and clear hit the same register in the same cycle, set wins.
- out_valid:
  - Set on accept.
  - Cleared on out_ready when there is no accept in that cycle.
  - Held with unchanged contents while out_ready is low.
- Out-of-range addresses (r >= DEPTH):
  - Never hazard.
  - Never set scoreboard bits.
  - Writeback to such an address is ignored.
- Writeback to a register with pend=0 clears nothing and still bypasses.

## Timing
- Reset values (async assert; deassertion is synchronous to clk externally):
  - out_valid=0; out_ctrl, out_op_a, out_op_b, out_rd, out_rd_we all 0; pend all 0.
  - in_ready=1 and hazard_stall=0 while rst_n is low.
- Reset mid-operation drops the held bundle and all pending marks; writebacks arriving after reset do nothing beyond bypass.
- Latency is 1 cycle: an instruction accepted at edge N shows out_valid after edge N.
- Back-to-back throughput is 1/cycle when out_ready=1 and no hazard.
- in_ready depends combinationally on out_ready, wb_*, and in_* addresses; there is no combinational path from in_valid to in_ready.
- Dependent pair: with writeback k cycles after ALU acceptance, the consumer stalls until the wb cycle and issues in that same cycle using the bypass.
- Operands in the output register are never stale: the scoreboard blocks issue until the producing write lands.

## Test plan
- Reset then three independent instructions (r0+r1→r2, r0→r1 with no rd_we, etc.), out_ready=1 → out_valid in consecutive cycles, operands equal the RF contents, hazard_stall never asserts.
- Issue a write to r2, then a reader of rs_a=r2; drive wb_we, wb_addr=2, wb_data=0x5A three cycles later → hazard_stall high for the intervening cycles, the reader is accepted in the wb cycle, and out_op_a=0x5A.
- Hold out_ready=0 for 4 cycles with out_valid=1 → in_ready=0, out_* stable; release → the next instruction is accepted in the same cycle.
- In the same cycle, a wb to r1 clears pend[1] and a new instruction with rd=r1 is accepted → pend[1]=1 afterwards (set wins) and a later reader of r1 stalls.
- Addresses rs_a=3 and rd=3 with DEPTH=3 → out_op_a=0, no stall, pend unchanged; wb to address 3 is ignored.
- Assert rst_n=0 while pend[0]=1 and out_valid=1 → out_valid=0 immediately and pend cleared; after release, a reader of r0 issues without stall.

Source files
------------

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch
//  Description : Issue / operand-fetch stage between decode and the ALU.
//                Drives the register-file read addresses, bypasses same-cycle
//                writeback data into the operands, tracks in-flight writes in
//                a per-register scoreboard (RAW/WAW stall) and hands fetched
//                operands to the ALU through a one-entry valid/ready register.
//  Ports       : clk, rst_n            clock, async active-low reset
//                in_*                  decoded instruction + handshake
//                rf_rd_addr_*/data_*   register-file read ports (async read)
//                wb_*                  writeback port (same as RF write port)
//                out_*                 operand bundle + handshake to the ALU
//                hazard_stall          instruction present but blocked
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter  int BUS_WIDTH  = 8,
    parameter  int DEPTH      = 3,
    parameter  int CTRL_WIDTH = 6,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // decoded instruction
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [AW-1:0]         in_rs_a,
    input  logic [AW-1:0]         in_rs_b,
    input  logic [AW-1:0]         in_rd,
    input  logic                  in_rd_we,
    // register-file read ports
    output logic [AW-1:0]         rf_rd_addr_a,
    output logic [AW-1:0]         rf_rd_addr_b,
    input  logic [BUS_WIDTH-1:0]  rf_rd_data_a,
    input  logic [BUS_WIDTH-1:0]  rf_rd_data_b,
    // writeback
    input  logic                  wb_we,
    input  logic [AW-1:0]         wb_addr,
    input  logic [BUS_WIDTH-1:0]  wb_data,
    // operand bundle to the ALU
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [BUS_WIDTH-1:0]  out_op_a,
    output logic [BUS_WIDTH-1:0]  out_op_b,
    output logic [AW-1:0]         out_rd,
    output logic                  out_rd_we,
    output logic                  hazard_stall
);

    // Scoreboard and output register
    logic [DEPTH-1:0]      r_pend;
    logic                  r_out_valid;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;
    logic [BUS_WIDTH-1:0]  r_out_op_a;
    logic [BUS_WIDTH-1:0]  r_out_op_b;
    logic [AW-1:0]         r_out_rd;
    logic                  r_out_rd_we;

    // Per-register decode. Addresses >= DEPTH match no bit, so they never
    // hazard, never set a pending mark and their writebacks clear nothing.
    logic [DEPTH-1:0]      w_clr;
    logic [DEPTH-1:0]      w_live;
    logic [DEPTH-1:0]      w_hit_a;
    logic [DEPTH-1:0]      w_hit_b;
    logic [DEPTH-1:0]      w_hit_rd;
    logic [DEPTH-1:0]      w_set;

    logic                  w_hazard;
    logic                  w_accept;
    logic [BUS_WIDTH-1:0]  w_op_a;
    logic [BUS_WIDTH-1:0]  w_op_b;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        assign w_clr[gi]    = wb_we && (wb_addr == AW'(gi));
        // A pending write that lands this cycle no longer blocks: the
        // consumer picks the value up through the bypass.
        assign w_live[gi]   = r_pend[gi] && !w_clr[gi];
        assign w_hit_a[gi]  = (in_rs_a == AW'(gi));
        assign w_hit_b[gi]  = (in_rs_b == AW'(gi));
        assign w_hit_rd[gi] = (in_rd   == AW'(gi));
        assign w_set[gi]    = w_accept && in_rd_we && w_hit_rd[gi];
    end

    assign w_hazard = (|(w_live & w_hit_a))
                   || (|(w_live & w_hit_b))
                   || (in_rd_we && (|(w_live & w_hit_rd)));

    // in_ready deliberately does not look at in_valid.
    assign in_ready     = (!r_out_valid || out_ready) && !w_hazard;
    assign hazard_stall = in_valid && w_hazard;
    assign w_accept     = in_valid && in_ready;

    assign rf_rd_addr_a = in_rs_a;
    assign rf_rd_addr_b = in_rs_b;

    // Operand select: out-of-range reads return zero, a same-cycle
    // writeback to the source overrides the (still old) RF read data.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        if (|w_hit_a) begin
            w_op_a = (|(w_clr & w_hit_a)) ? wb_data : rf_rd_data_a;
        end
        if (|w_hit_b) begin
            w_op_b = (|(w_clr & w_hit_b)) ? wb_data : rf_rd_data_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= '0;
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
            r_out_op_a  <= '0;
            r_out_op_b  <= '0;
            r_out_rd    <= '0;
            r_out_rd_we <= 1'b0;
        end else begin
            // Set is ORed in after the clear so a new producer wins over
            // a writeback retiring the previous one on the same register.
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_ctrl  <= in_ctrl;
                r_out_op_a  <= w_op_a;
                r_out_op_b  <= w_op_b;
                r_out_rd    <= in_rd;
                r_out_rd_we <= in_rd_we;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_ctrl  = r_out_ctrl;
    assign out_op_a  = r_out_op_a;
    assign out_op_b  = r_out_op_b;
    assign out_rd    = r_out_rd;
    assign out_rd_we = r_out_rd_we;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_fetch
//  Description : Directed self-checking bench for operand_fetch with a
//                register-file model and an expected-bundle queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_ctrl;
    logic [1:0] in_rs_a, in_rs_b, in_rd;
    logic       in_rd_we;
    logic [1:0] rf_rd_addr_a, rf_rd_addr_b;
    logic [7:0] rf_rd_data_a, rf_rd_data_b;
    logic       wb_we;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_ctrl;
    logic [7:0] out_op_a, out_op_b;
    logic [1:0] out_rd;
    logic       out_rd_we;
    logic       hazard_stall;

    int checks = 0;
    int errors = 0;

    // {ctrl, op_a, op_b, rd, rd_we}
    logic [24:0] exp_q[$];

    // Register-file model: async read, written by the writeback port.
    logic [7:0] rf [0:2] = '{8'h11, 8'h22, 8'h33};
    assign rf_rd_data_a = (rf_rd_addr_a < 2'd3) ? rf[rf_rd_addr_a] : 8'hEE;
    assign rf_rd_data_b = (rf_rd_addr_b < 2'd3) ? rf[rf_rd_addr_b] : 8'hEE;
    always @(posedge clk) begin
        if (wb_we && wb_addr < 2'd3) rf[wb_addr] <= wb_data;
    end

    operand_fetch #(.BUS_WIDTH(8), .DEPTH(3), .CTRL_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .hazard_stall(hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] opnd(input logic [1:0] r);
        if (r >= 2'd3) return 8'h00;
        if (wb_we && wb_addr == r) return wb_data;
        return rf[r];
    endfunction

    task automatic drive(input logic v, input logic [5:0] c, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] d, input logic we);
        in_valid = v; in_ctrl = c; in_rs_a = a; in_rs_b = b; in_rd = d; in_rd_we = we;
    endtask

    task automatic wb(input logic we, input logic [1:0] a, input logic [7:0] d);
        wb_we = we; wb_addr = a; wb_data = d;
    endtask

    // One clock: check handshake/stall, check the held bundle against the
    // queue head (popped when consumed), queue the accepted instruction.
    task automatic step(input string tag, input logic exp_rdy,
                        input logic exp_stall, input logic exp_ov);
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        chk({tag, ".hazard_stall"}, 32'(hazard_stall), 32'(exp_stall));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
        chk({tag, ".rf_addr_a"}, 32'(rf_rd_addr_a), 32'(in_rs_a));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".unexpected_bundle"}, 32'(out_valid), 32'd0);
            end else begin
                chk({tag, ".bundle"},
                    32'({out_ctrl, out_op_a, out_op_b, out_rd, out_rd_we}),
                    32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (in_valid && exp_rdy)
            exp_q.push_back({in_ctrl, opnd(in_rs_a), opnd(in_rs_b), in_rd, in_rd_we});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 6'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        wb(1'b0, 2'd0, 8'h00);
        #2;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.bundle", 32'({out_ctrl, out_op_a, out_op_b, out_rd, out_rd_we}), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.hazard_stall", 32'(hazard_stall), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Independent instructions, full throughput
        drive(1'b1, 6'h01, 2'd0, 2'd1, 2'd2, 1'b0); step("ind_a", 1, 0, 0);
        drive(1'b1, 6'h02, 2'd0, 2'd2, 2'd1, 1'b0); step("ind_b", 1, 0, 1);
        drive(1'b1, 6'h03, 2'd2, 2'd1, 2'd0, 1'b0); step("ind_c", 1, 0, 1);
        drive(1'b0, 6'h00, 2'd0, 2'd0, 2'd0, 1'b0); step("ind_drain", 1, 0, 1);

        // RAW on r2, resolved by writeback bypass three cycles later
        drive(1'b1, 6'h05, 2'd0, 2'd0, 2'd2, 1'b1); step("raw_prod", 1, 0, 0);
        drive(1'b1, 6'h06, 2'd2, 2'd1, 2'd0, 1'b0); step("raw_st1", 0, 1, 1);
        step("raw_st2", 0, 1, 0);
        step("raw_st3", 0, 1, 0);
        wb(1'b1, 2'd2, 8'h5A);                     step("raw_wb", 1, 0, 0);
        wb(1'b0, 2'd0, 8'h00);
        drive(1'b0, 6'h00, 2'd0, 2'd0, 2'd0, 1'b0); step("raw_drain", 1, 0, 1);

        // Backpressure: bundle held stable while out_ready is low
        out_ready = 1'b0;
        drive(1'b1, 6'h09, 2'd0, 2'd1, 2'd1, 1'b0); step("bp_i1", 1, 0, 0);
        drive(1'b1, 6'h0A, 2'd2, 2'd0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) step("bp_hold", 0, 0, 1);
        out_ready = 1'b1;                           step("bp_release", 1, 0, 1);
        drive(1'b0, 6'h00, 2'd0, 2'd0, 2'd0, 1'b0); step("bp_drain", 1, 0, 1);

        // Set wins over a same-cycle clear on r1
        drive(1'b1, 6'h11, 2'd2, 2'd2, 2'd1, 1'b1); step("sw_prod1", 1, 0, 0);
        wb(1'b1, 2'd1, 8'h77);
        drive(1'b1, 6'h12, 2'd0, 2'd0, 2'd1, 1'b1); step("sw_prod2", 1, 0, 1);
        wb(1'b0, 2'd0, 8'h00);
        drive(1'b1, 6'h13, 2'd1, 2'd0, 2'd2, 1'b0); step("sw_st1", 0, 1, 1);
        step("sw_st2", 0, 1, 0);
        wb(1'b1, 2'd1, 8'h88);                     step("sw_wb", 1, 0, 0);
        wb(1'b0, 2'd0, 8'h00);
        drive(1'b0, 6'h00, 2'd0, 2'd0, 2'd0, 1'b0); step("sw_drain", 1, 0, 1);

        // Out-of-range register address 3
        drive(1'b1, 6'h21, 2'd3, 2'd0, 2'd3, 1'b1); step("oor_a", 1, 0, 0);
        wb(1'b1, 2'd3, 8'hFF);
        drive(1'b1, 6'h22, 2'd3, 2'd3, 2'd3, 1'b1); step("oor_b", 1, 0, 1);
        wb(1'b0, 2'd0, 8'h00);
        drive(1'b1, 6'h23, 2'd2, 2'd1, 2'd0, 1'b0); step("oor_c", 1, 0, 1);
        drive(1'b0, 6'h00, 2'd0, 2'd0, 2'd0, 1'b0); step("oor_drain", 1, 0, 1);

        // Reset with a held bundle and pend[0] set
        out_ready = 1'b0;
        drive(1'b1, 6'h31, 2'd1, 2'd2, 2'd0, 1'b1); step("rst_prod", 1, 0, 0);
        drive(1'b1, 6'h32, 2'd0, 2'd1, 2'd2, 1'b0); step("rst_pre", 0, 1, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid.bundle", 32'({out_ctrl, out_op_a, out_op_b, out_rd, out_rd_we}), 32'd0);
        chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid.hazard_stall", 32'(hazard_stall), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        step("rst_after", 1, 0, 0);
        drive(1'b0, 6'h00, 2'd0, 2'd0, 2'd0, 1'b0); step("rst_drain", 1, 0, 1);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
